// File: rtl/sar_pkg.sv
// Shared constants and FSM encoding for the SAR result read path.
package sar_pkg;

    localparam int SAR_DATA_W  = 12;
    localparam int SPI_FRAME_W = 16;

    localparam int VALID_BIT = SPI_FRAME_W - 1;
    localparam int OVF_BIT   = SPI_FRAME_W - 2;

    typedef logic [1:0] spi_state_t;

    localparam spi_state_t ST_IDLE  = 2'd0;
    localparam spi_state_t ST_LOAD  = 2'd1;
    localparam spi_state_t ST_SHIFT = 2'd2;
    localparam spi_state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/sar_result_spi_tx_if.sv
// SPI pad bundle between an external master and the result transmitter.
interface sar_result_spi_tx_if;

    logic sclk;
    logic cs_n;
    logic miso;
    logic miso_oe;

    modport master (
        output sclk,
        output cs_n,
        input  miso,
        input  miso_oe
    );

    modport slave (
        input  sclk,
        input  cs_n,
        output miso,
        output miso_oe
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO; an extra pointer MSB separates full from empty.
module sync_fifo #(
    parameter int DATA_W = 12,
    parameter int DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push_i,
    input  logic [DATA_W-1:0]         data_i,
    input  logic                      pop_i,
    output logic [DATA_W-1:0]         data_o,
    output logic                      full_o,
    output logic                      empty_o,
    output logic [$clog2(DEPTH):0]    count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic              wr_en;
    logic              rd_en;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

    // Pop frees a slot first, so a push into a full FIFO still lands.
    assign rd_en = pop_i & ~empty_o;
    assign wr_en = push_i & (~full_o | rd_en);

    assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, wr_en};
    assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, rd_en};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/sar_result_spi_tx.sv
// Buffers SAR conversion results and shifts them out as an SPI mode-0 slave.
module sar_result_spi_tx
    import sar_pkg::*;
#(
    parameter int DATA_W  = SAR_DATA_W,
    parameter int DEPTH   = 4,
    parameter int FRAME_W = SPI_FRAME_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_W-1:0]       result_i,
    input  logic                    done_i,
    sar_result_spi_tx_if.slave      spi,
    output logic [$clog2(DEPTH):0]  fifo_count_o,
    output logic                    data_ready_o,
    output logic                    overflow_o
);

    localparam int VLD   = FRAME_W - 1;
    localparam int OVF   = FRAME_W - 2;
    localparam int CNT_W = $clog2(FRAME_W + 1);

    logic cs_s1_q, cs_s2_q, cs_d_q;
    logic sck_s1_q, sck_s2_q, sck_d_q;
    logic cs_fall, cs_rise, sck_fall;

    spi_state_t         state_q, state_d;
    logic [FRAME_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;

    logic [FRAME_W-1:0] frame;
    logic [DATA_W-1:0]  head;
    logic               full, empty;
    logic               pop, load, drop;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (done_i),
        .data_i  (result_i),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (fifo_count_o)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_s1_q  <= 1'b1;
            cs_s2_q  <= 1'b1;
            cs_d_q   <= 1'b1;
            sck_s1_q <= 1'b0;
            sck_s2_q <= 1'b0;
            sck_d_q  <= 1'b0;
        end else begin
            cs_s1_q  <= spi.cs_n;
            cs_s2_q  <= cs_s1_q;
            cs_d_q   <= cs_s2_q;
            sck_s1_q <= spi.sclk;
            sck_s2_q <= sck_s1_q;
            sck_d_q  <= sck_s2_q;
        end
    end

    assign cs_fall  = cs_d_q & ~cs_s2_q;
    assign cs_rise  = ~cs_d_q & cs_s2_q;
    assign sck_fall = sck_d_q & ~sck_s2_q;

    always_comb begin
        frame            = '0;
        frame[VLD]       = ~empty;
        frame[OVF]       = ovf_q;
        frame[DATA_W-1:0] = empty ? '0 : head;
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        load    = 1'b0;
        if (cs_rise) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (cs_fall) state_d = ST_LOAD;
                end
                ST_LOAD: begin
                    load    = 1'b1;
                    pop     = ~empty;
                    shreg_d = frame;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (sck_fall) begin
                        shreg_d = {shreg_q[FRAME_W-2:0], 1'b0};
                        cnt_d   = cnt_q + 1'b1;
                        if (cnt_q == CNT_W'(FRAME_W - 1)) state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // A drop in the load cycle must survive the clear.
    assign drop  = done_i & full & ~pop;
    assign ovf_d = drop ? 1'b1 : (load ? 1'b0 : ovf_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign spi.miso      = (state_q == ST_SHIFT) & shreg_q[FRAME_W-1];
    assign spi.miso_oe   = ~cs_s2_q;
    assign data_ready_o  = ~empty;
    assign overflow_o    = ovf_q;

endmodule
